// File: rtl/posit_decode_pipe_pkg.sv
// rtl/posit_decode_pipe_pkg.sv - shared widths and helpers for the posit decode pipeline
package posit_pkg;

    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 2;
    localparam int FRAC_W   = POSIT_N - 1 - POSIT_ES;

    function automatic int regime_width(input int n);
        return $clog2(n);
    endfunction

    function automatic int frac_width(input int n, input int es);
        return n - 1 - es;
    endfunction

endpackage

// File: rtl/posit_regime_run.sv
// rtl/posit_regime_run.sv - regime run length of a sign-normalised posit body
module posit_regime_run
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int RS = regime_width(N)
) (
    input  logic [N-2:0] remain,
    output logic [RS:0]  m,
    output logic         first
);

    logic run;

    always_comb begin
        first = remain[N-2];
        m     = {{RS{1'b0}}, 1'b1};
        run   = 1'b1;
        for (int i = N - 3; i >= 0; i--) begin
            if (run && (remain[i] == first)) begin
                m = m + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage posit field decoder with valid/ready and sticky NaR flag
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int RS = regime_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_posit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic signed [RS:0] out_k,
    output logic [ES-1:0]     out_exp,
    output logic [N-1:0]      out_mant,
    output logic              out_inf,
    output logic              out_zero,
    output logic              nar_seen,
    input  logic              nar_clr
);

    localparam int FW = frac_width(N, ES);

    typedef struct packed {
        logic               sign;
        logic signed [RS:0] k;
        logic [ES-1:0]      exp;
        logic [N-1:0]       mant;
        logic               inf;
        logic               zero;
    } dec_t;

    logic          s1_valid;
    logic          s1_sign;
    logic          s1_inf;
    logic          s1_zero;
    logic [N-2:0]  s1_remain;
    logic          s2_valid;
    dec_t          s2;

    logic          s2_load;
    logic          nar_set;
    logic [N-2:0]  in_body;
    logic [N-2:0]  in_remain;
    logic [RS:0]   run_m;
    logic          run_first;
    logic [RS+1:0] shamt;
    logic [N-2:0]  shifted;
    dec_t          dec;

    // out_ready -> in_ready is the only combinational path through the block
    assign s2_load   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_load;
    assign nar_set   = s2_valid & out_ready & s2.inf;

    assign in_body   = in_posit[N-2:0];
    assign in_remain = in_posit[N-1] ? -in_body : in_body;

    posit_regime_run #(.N(N), .RS(RS)) u_regime_run (
        .remain (s1_remain),
        .m      (run_m),
        .first  (run_first)
    );

    always_comb begin
        shamt    = {1'b0, run_m} + 1'b1;
        shifted  = s1_remain << shamt;
        dec      = '0;
        dec.sign = s1_sign;
        dec.inf  = s1_inf;
        dec.zero = s1_zero;
        if (!(s1_inf || s1_zero)) begin
            dec.k    = run_first ? (run_m - 1'b1) : -run_m;
            dec.exp  = shifted[N-2 -: ES];
            dec.mant = {1'b1, shifted[FW-1:0], {ES{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_remain <= '0;
            s2_valid  <= 1'b0;
            s2        <= '0;
            nar_seen  <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign   <= in_posit[N-1];
                    s1_inf    <= in_posit[N-1] & ~|in_body;
                    s1_zero   <= ~|in_posit;
                    s1_remain <= in_remain;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2 <= dec;
                end
            end
            // a NaR leaving the block outranks a simultaneous clear
            if (nar_set) begin
                nar_seen <= 1'b1;
            end else if (nar_clr) begin
                nar_seen <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_sign  = s2.sign;
    assign out_k     = s2.k;
    assign out_exp   = s2.exp;
    assign out_mant  = s2.mant;
    assign out_inf   = s2.inf;
    assign out_zero  = s2.zero;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - self-checking bench for posit_decode_pipe
module tb_posit_decode_pipe;

    localparam int N  = 8;
    localparam int ES = 2;
    localparam int RS = 3;
    localparam int PW = 1 + (RS + 1) + ES + N + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_posit;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic signed [RS:0] out_k;
    logic [ES-1:0]     out_exp;
    logic [N-1:0]      out_mant;
    logic              out_inf;
    logic              out_zero;
    logic              nar_seen;
    logic              nar_clr;

    always #5 clk = ~clk;

    posit_decode_pipe #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_k     (out_k),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_inf   (out_inf),
        .out_zero  (out_zero),
        .nar_seen  (nar_seen),
        .nar_clr   (nar_clr)
    );

    int            checks = 0;
    int            errors = 0;
    int            pushes = 0;
    int            pops   = 0;
    logic [PW-1:0] q[$];
    bit            nar_exp    = 1'b0;
    bit            stall_prev = 1'b0;
    logic [PW-1:0] held;
    logic [PW-1:0] obs;

    assign obs = {out_sign, out_k, out_exp, out_mant, out_inf, out_zero};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [PW-1:0] pk(input int s, input int k, input int e,
                                         input int mt, input int inf, input int zr);
        logic [PW-1:0] r;
        r = {s[0], k[RS:0], e[ES-1:0], mt[N-1:0], inf[0], zr[0]};
        return r;
    endfunction

    // Reference: strip sign by two's complement, walk the regime bit by bit, then read exp/fraction
    function automatic logic [PW-1:0] ref_decode(input logic [N-1:0] p);
        int mask, s, body, r, first, m, rest, k, e, frac, mant;
        mask = (1 << (N - 1)) - 1;
        s    = int'(p) >> (N - 1);
        body = int'(p) & mask;
        if (body == 0) return pk(s, 0, 0, 0, s, (s == 0) ? 1 : 0);
        r     = (s != 0) ? (((1 << (N - 1)) - body) & mask) : body;
        first = (r >> (N - 2)) & 1;
        m     = 0;
        rest  = r;
        while (m < N - 1 && ((rest >> (N - 2)) & 1) == first) begin
            m++;
            rest = (rest << 1) & mask;
        end
        rest = (rest << 1) & mask;
        k    = (first != 0) ? m - 1 : -m;
        e    = rest >> (N - 1 - ES);
        frac = rest & ((1 << (N - 1 - ES)) - 1);
        mant = (1 << (N - 1)) | (frac << ES);
        return pk(s, k, e, mant, 0, 0);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            nar_exp    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_stable", 32'(obs), 32'(held));
            check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            check("nar_seen", 32'(nar_seen), 32'(nar_exp));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'(0));
                end else begin
                    check("sb_fields", 32'(obs), 32'(q.pop_front()));
                end
                pops++;
                if (out_inf) nar_exp = 1'b1;
                else if (nar_clr) nar_exp = 1'b0;
            end else if (nar_clr) begin
                nar_exp = 1'b0;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_decode(in_posit));
                pushes++;
            end
            stall_prev = out_valid && !out_ready;
            held       = obs;
        end
    end

    task automatic send(input logic [N-1:0] w);
        int tries = 0;
        bit ok    = 1'b0;
        in_valid = 1'b1;
        in_posit = w;
        while (!ok && tries < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        check("send_accept", 32'(ok), 32'(1));
    endtask

    task automatic expect_one(input string tag, input int lat, input logic [PW-1:0] want);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check(tag, 32'(obs), 32'(want));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, pop0, cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_posit  = '0;
        out_ready = 1'b1;
        nar_clr   = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_nar_seen", 32'(nar_seen), 32'(0));
        check("rst_fields", 32'(obs), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'(1));

        send(8'h40); expect_one("d40", 2, pk(0, 0, 0, 'h80, 0, 0));
        send(8'h5A); expect_one("d5a", 2, pk(0, 0, 3, 'hA0, 0, 0));
        send(8'h40); send(8'h5A);
        expect_one("b2b_40", 1, pk(0, 0, 0, 'h80, 0, 0));
        expect_one("b2b_5a", 1, pk(0, 0, 3, 'hA0, 0, 0));
        send(8'hC0); expect_one("dc0", 2, pk(1, 0, 0, 'h80, 0, 0));
        send(8'h08); expect_one("d08", 2, pk(0, -3, 0, 'h80, 0, 0));
        send(8'h7F); expect_one("d7f", 2, pk(0, 6, 0, 'h80, 0, 0));

        send(8'h80); expect_one("d80", 2, pk(1, 0, 0, 0, 1, 0));
        check("nar_after_nar", 32'(nar_seen), 32'(1));
        send(8'h00); expect_one("d00", 2, pk(0, 0, 0, 0, 0, 1));
        check("nar_after_zero", 32'(nar_seen), 32'(1));
        nar_clr = 1'b1;
        @(posedge clk); #1;
        nar_clr = 1'b0;
        check("nar_cleared", 32'(nar_seen), 32'(0));
        send(8'h80);
        nar_clr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nar_clr = 1'b0;
        check("nar_set_wins", 32'(nar_seen), 32'(1));

        pop0      = pops;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_posit  = 8'h40;
        @(posedge clk); #1;
        in_posit  = 8'h5A;
        @(posedge clk); #1;
        in_posit  = 8'h08;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'(0));
            check("stall_head", 32'(obs), 32'(pk(0, 0, 0, 'h80, 0, 0)));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_drain_count", 32'(pops - pop0), 32'(3));
        check("stall_drain_empty", 32'(q.size()), 32'(0));

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_posit  = 8'h7F;
        @(posedge clk); #1;
        in_posit  = 8'h80;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'(0));
        check("async_nar_seen", 32'(nar_seen), 32'(0));
        check("async_fields", 32'(obs), 32'(0));
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        send(8'h40); expect_one("post_rst_40", 2, pk(0, 0, 0, 'h80, 0, 0));

        p0  = pushes;
        cyc = 0;
        while ((pushes - p0) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_posit  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            nar_clr   = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_words", 32'((pushes - p0) >= 10000), 32'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nar_clr   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rand_drain_empty", 32'(q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
